// File: rtl/lfsr_sequence_checker.sv
// Receive-side Galois-LFSR sequence checker: self-synchronises on incoming words,
// locks after a run of correct successors, then flywheels its prediction to count errors.
module lfsr_sequence_checker #(
  parameter int unsigned NUM_BITS = 16,
  parameter logic [NUM_BITS-1:0] FEEDBACK_POLY = NUM_BITS'(16'hD008),
  parameter int unsigned LOCK_COUNT = 4,
  parameter int unsigned UNLOCK_ERRORS = 3
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                i__valid,
  input  logic [NUM_BITS-1:0] i__value,
  input  logic                i__clear_counts,
  output logic                o__locked,
  output logic                o__error,
  output logic [NUM_BITS-1:0] o__expected,
  output logic [31:0]         o__match_count,
  output logic [31:0]         o__error_count
);

  localparam int unsigned RUN_MAX = (LOCK_COUNT > UNLOCK_ERRORS) ? LOCK_COUNT : UNLOCK_ERRORS;
  localparam int unsigned RUN_W   = $clog2(RUN_MAX) + 1;
  localparam int unsigned CNT_W   = 32;

  if (NUM_BITS < 2 || NUM_BITS > 52 || FEEDBACK_POLY == '0 ||
      LOCK_COUNT < 1 || UNLOCK_ERRORS < 1) begin : g_param_check
    $error("lfsr_sequence_checker: illegal parameter combination");
  end

  typedef enum logic [1:0] {HUNT, VERIFY, LOCKED} state_t;

  state_t              state_q, state_d;
  logic [RUN_W-1:0]    r__run, run_d;
  logic [NUM_BITS-1:0] expected_d;
  logic                error_d;
  logic                match_inc, error_inc;
  logic [CNT_W-1:0]    match_count_d, error_count_d;

  function automatic logic [NUM_BITS-1:0] next_word(input logic [NUM_BITS-1:0] v);
    return v[0] ? ((v >> 1) ^ FEEDBACK_POLY) : (v >> 1);
  endfunction

  // Next-state, prediction and statistics logic
  always_comb begin
    state_d    = state_q;
    run_d      = r__run;
    expected_d = o__expected;
    error_d    = 1'b0;
    match_inc  = 1'b0;
    error_inc  = 1'b0;
    if (i__valid) begin
      unique case (state_q)
        HUNT: begin
          if (i__value != '0) begin
            expected_d = next_word(i__value);
            run_d      = '0;
            state_d    = VERIFY;
          end
        end
        VERIFY: begin
          if (i__value == o__expected) begin
            expected_d = next_word(i__value);
            if (r__run + RUN_W'(1) == RUN_W'(LOCK_COUNT)) begin
              state_d = LOCKED;
              run_d   = '0;
            end else begin
              run_d = r__run + RUN_W'(1);
            end
          end else if (i__value != '0) begin
            expected_d = next_word(i__value);
            run_d      = '0;
          end else begin
            state_d = HUNT;
            run_d   = '0;
          end
        end
        LOCKED: begin
          // Flywheel: prediction advances from itself, never from the received word
          expected_d = next_word(o__expected);
          if (i__value == o__expected) begin
            match_inc = 1'b1;
            run_d     = '0;
          end else begin
            error_d   = 1'b1;
            error_inc = 1'b1;
            if (r__run + RUN_W'(1) == RUN_W'(UNLOCK_ERRORS)) begin
              state_d = HUNT;
              run_d   = '0;
            end else begin
              run_d = r__run + RUN_W'(1);
            end
          end
        end
        default: begin
          state_d = HUNT;
          run_d   = '0;
        end
      endcase
    end

    match_count_d = o__match_count;
    error_count_d = o__error_count;
    if (i__clear_counts) begin
      match_count_d = '0;
      error_count_d = '0;
    end else begin
      if (match_inc && o__match_count != '1) match_count_d = o__match_count + CNT_W'(1);
      if (error_inc && o__error_count != '1) error_count_d = o__error_count + CNT_W'(1);
    end
  end

  // State and registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= HUNT;
      r__run         <= '0;
      o__locked      <= 1'b0;
      o__error       <= 1'b0;
      o__expected    <= '0;
      o__match_count <= '0;
      o__error_count <= '0;
    end else begin
      state_q        <= state_d;
      r__run         <= run_d;
      o__locked      <= (state_d == LOCKED);
      o__error       <= error_d;
      o__expected    <= expected_d;
      o__match_count <= match_count_d;
      o__error_count <= error_count_d;
    end
  end

endmodule

// File: tb/tb_lfsr_sequence_checker.sv
// Self-checking bench for lfsr_sequence_checker: directed scenarios plus a randomized
// stream, all compared against a behavioural model of the lock/flywheel rules.
module tb_lfsr_sequence_checker;

  localparam int unsigned NB   = 16;
  localparam logic [15:0] POLY = 16'hD008;
  localparam int          LOCK = 4;
  localparam int          UNLK = 3;

  logic        clk = 1'b0;
  logic        reset;
  logic        i__valid;
  logic [15:0] i__value;
  logic        i__clear_counts;
  logic        o__locked;
  logic        o__error;
  logic [15:0] o__expected;
  logic [31:0] o__match_count;
  logic [31:0] o__error_count;

  int errors = 0;
  int checks = 0;

  lfsr_sequence_checker #(
    .NUM_BITS(NB), .FEEDBACK_POLY(POLY), .LOCK_COUNT(LOCK), .UNLOCK_ERRORS(UNLK)
  ) dut (
    .clk(clk), .reset(reset), .i__valid(i__valid), .i__value(i__value),
    .i__clear_counts(i__clear_counts), .o__locked(o__locked), .o__error(o__error),
    .o__expected(o__expected), .o__match_count(o__match_count),
    .o__error_count(o__error_count)
  );

  always #5 clk = ~clk;

  // Behavioural model: mode 0 = searching, 1 = confirming, 2 = locked
  int          m_mode;
  int          m_run;
  logic [15:0] m_exp;
  bit          m_err;
  logic [31:0] m_mc, m_ec;

  function automatic logic [15:0] ref_next(input logic [15:0] v);
    int unsigned x = v;
    if (x % 2 == 1) return 16'((x / 2) ^ POLY);
    return 16'(x / 2);
  endfunction

  task automatic model_reset();
    m_mode = 0; m_run = 0; m_exp = 16'h0; m_err = 0; m_mc = 0; m_ec = 0;
  endtask

  task automatic model_update(input bit v, input logic [15:0] w, input bit clr);
    bit hit = 0, miss = 0;
    m_err = 0;
    if (v) begin
      if (m_mode == 0) begin
        if (w != 0) begin m_exp = ref_next(w); m_run = 0; m_mode = 1; end
      end else if (m_mode == 1) begin
        if (w == m_exp) begin
          m_exp = ref_next(w);
          m_run = m_run + 1;
          if (m_run == LOCK) begin m_mode = 2; m_run = 0; end
        end else if (w != 0) begin
          m_exp = ref_next(w); m_run = 0;
        end else begin
          m_mode = 0; m_run = 0;
        end
      end else begin
        hit  = (w == m_exp);
        miss = !hit;
        m_exp = ref_next(m_exp);
        if (hit) m_run = 0;
        else begin
          m_err = 1;
          m_run = m_run + 1;
          if (m_run == UNLK) begin m_mode = 0; m_run = 0; end
        end
      end
    end
    if (clr) begin
      m_mc = 0; m_ec = 0;
    end else begin
      if (hit  && m_mc != 32'hFFFF_FFFF) m_mc = m_mc + 1;
      if (miss && m_ec != 32'hFFFF_FFFF) m_ec = m_ec + 1;
    end
  endtask

  function automatic logic [81:0] obs();
    return {o__locked, o__error, o__expected, o__match_count, o__error_count};
  endfunction

  function automatic logic [81:0] expv();
    return {(m_mode == 2), m_err, m_exp, m_mc, m_ec};
  endfunction

  task automatic step(input bit v, input logic [15:0] w, input bit clr);
    @(negedge clk);
    i__valid = v; i__value = w; i__clear_counts = clr;
    @(posedge clk);
    model_update(v, w, clr);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; i__valid = 1'b0; i__value = 16'h0; i__clear_counts = 1'b0;
    @(posedge clk);
    model_reset();
    #1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic drive_lock(input logic [15:0] seed);
    logic [15:0] w = seed;
    step(1, w, 0);
    for (int k = 0; k < LOCK; k++) begin
      w = ref_next(w);
      step(1, w, 0);
    end
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (obs() !== 82'h0) begin
      errors++;
      $display("FAIL reset_state: got %h need 0", obs());
    end
  endtask

  task automatic test_clean_lock();
    logic [15:0] words [5] = '{16'h0001, 16'hD008, 16'h6804, 16'h3402, 16'h1A01};
    do_reset();
    for (int i = 0; i < 5; i++) begin
      step(1, words[i], 0);
      checks++;
      if (obs() !== expv()) begin
        errors++;
        $display("FAIL clean_lock word %0d: got %h need %h", i, obs(), expv());
      end
    end
    checks++;
    if ({o__locked, o__error, o__expected, o__match_count, o__error_count} !==
        {1'b1, 1'b0, 16'hDD08, 32'h0, 32'h0}) begin
      errors++;
      $display("FAIL clean_lock_final: locked=%b err=%b exp=%h mc=%0d ec=%0d need 1 0 dd08 0 0",
               o__locked, o__error, o__expected, o__match_count, o__error_count);
    end
  endtask

  task automatic test_gaps();
    step(1, 16'hDD08, 0);
    for (int i = 0; i < 3; i++) step(0, 16'hBEEF, 0);
    step(1, ref_next(16'hDD08), 0);
    checks++;
    if (obs() !== expv()) begin
      errors++;
      $display("FAIL gaps_model: got %h need %h", obs(), expv());
    end
    checks++;
    if (o__match_count !== 32'd2 || o__locked !== 1'b1 || o__error !== 1'b0) begin
      errors++;
      $display("FAIL gaps: mc=%0d locked=%b err=%b need 2 1 0", o__match_count, o__locked, o__error);
    end
  endtask

  task automatic test_single_error();
    do_reset();
    drive_lock(16'h0001);
    step(1, 16'hFFFF, 0);
    checks++;
    if (o__error !== 1'b1 || o__error_count !== 32'd1) begin
      errors++;
      $display("FAIL single_error_pulse: err=%b ec=%0d need 1 1", o__error, o__error_count);
    end
    step(1, ref_next(16'hDD08), 0);
    checks++;
    if ({o__locked, o__error, o__match_count, o__error_count} !== {1'b1, 1'b0, 32'd1, 32'd1}) begin
      errors++;
      $display("FAIL single_error_after: locked=%b err=%b mc=%0d ec=%0d need 1 0 1 1",
               o__locked, o__error, o__match_count, o__error_count);
    end
  endtask

  task automatic test_loss_of_lock();
    logic [15:0] bad [3] = '{16'hFFFF, 16'h1111, 16'h0000};
    do_reset();
    drive_lock(16'h0001);
    for (int i = 0; i < 3; i++) begin
      step(1, bad[i], 0);
      checks++;
      if (o__error !== 1'b1 || o__locked !== (i < 2) || o__error_count !== 32'(i + 1)) begin
        errors++;
        $display("FAIL loss_of_lock word %0d: err=%b locked=%b ec=%0d", i, o__error, o__locked,
                 o__error_count);
      end
    end
    step(0, 16'h0, 0);
    checks++;
    if (o__error !== 1'b0) begin
      errors++;
      $display("FAIL loss_pulse_width: err=%b need 0", o__error);
    end
    drive_lock(16'h00AB);
    checks++;
    if (o__locked !== 1'b1 || obs() !== expv()) begin
      errors++;
      $display("FAIL relock: got %h need %h", obs(), expv());
    end
  endtask

  task automatic test_zero_reseed();
    do_reset();
    for (int i = 0; i < 3; i++) step(1, 16'h0000, 0);
    checks++;
    if (o__expected !== 16'h0 || o__locked !== 1'b0) begin
      errors++;
      $display("FAIL zero_hunt: exp=%h locked=%b need 0000 0", o__expected, o__locked);
    end
    step(1, 16'h0001, 0);
    step(1, 16'h1234, 0);
    checks++;
    if ({o__expected, o__error, o__locked} !== {16'h091A, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL reseed: exp=%h err=%b locked=%b need 091a 0 0", o__expected, o__error, o__locked);
    end
  endtask

  task automatic test_clear();
    do_reset();
    drive_lock(16'h0001);
    step(1, 16'hDD08, 0);
    step(1, 16'h1234, 0);
    checks++;
    if (o__match_count !== 32'd1 || o__error_count !== 32'd1) begin
      errors++;
      $display("FAIL clear_pre: mc=%0d ec=%0d need 1 1", o__match_count, o__error_count);
    end
    step(1, ref_next(ref_next(16'hDD08)), 1);
    checks++;
    if (o__match_count !== 32'd0 || o__error_count !== 32'd0 || o__locked !== 1'b1) begin
      errors++;
      $display("FAIL clear_wins: mc=%0d ec=%0d locked=%b need 0 0 1", o__match_count,
               o__error_count, o__locked);
    end
  endtask

  task automatic test_reset_locked();
    do_reset();
    drive_lock(16'h0001);
    step(1, 16'hDD08, 0);
    do_reset();
    checks++;
    if (obs() !== 82'h0) begin
      errors++;
      $display("FAIL reset_locked: got %h need 0", obs());
    end
  endtask

  task automatic test_random();
    logic [15:0] g = 16'h0001;
    int          r;
    bit          clr;
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      r   = int'($urandom_range(0, 99));
      clr = ($urandom_range(0, 49) == 0);
      if (r < 20) step(0, 16'($urandom), clr);
      else if (r < 28) step(1, 16'($urandom), clr);
      else if (r < 30) step(1, 16'h0000, clr);
      else if (r < 31) begin
        g = 16'($urandom_range(1, 65535));
        step(1, g, clr);
        g = ref_next(g);
      end else begin
        step(1, g, clr);
        g = ref_next(g);
      end
      checks++;
      if (obs() !== expv()) begin
        errors++;
        $display("FAIL random cycle %0d: got %h need %h", i, obs(), expv());
      end
    end
  endtask

  initial begin
    reset = 1'b1; i__valid = 1'b0; i__value = 16'h0; i__clear_counts = 1'b0;
    model_reset();
    test_reset();
    test_clean_lock();
    test_gaps();
    test_single_error();
    test_loss_of_lock();
    test_zero_reseed();
    test_clear();
    test_reset_locked();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/lfsr_sequence_checker.md
# lfsr_sequence_checker

Receive-side companion to the testbench LFSR pattern generator: consumes a stream of NUM_BITS-wide pseudo-random words and verifies that each word is the Galois-LFSR successor of the previous one. It self-synchronises from the incoming data, declares lock after a run of correct words, then free-runs ("flywheels") its own prediction to count errors. It sits in testbench scoreboards at the far end of a DUT path driven by the generator.

## Interface
- NUM_BITS, 16, word width; legal 2..52.
- FEEDBACK_POLY, 16'hD008, NUM_BITS-wide Galois feedback mask; must equal the generator's mask for the same NUM_BITS.
- LOCK_COUNT, 4, consecutive correct words required to declare lock; ≥1.
- UNLOCK_ERRORS, 3, consecutive wrong words while locked that drop lock; ≥1.
- clk  input  1  clock.
- reset  input  1  synchronous, active-high.
- i__valid  input  1  i__value carries a word this cycle.
- i__value  input  NUM_BITS  received word.
- i__clear_counts  input  1  zero both statistics counters.
- o__locked  output  1  checker is locked.
- o__error  output  1  one-cycle pulse: a locked-state word mismatched.
- o__expected  output  NUM_BITS  word predicted for the next valid input.
- o__match_count  output  32  correct words seen while locked, saturating.
- o__error_count  output  32  wrong words seen while locked, saturating.

## Operation
- Successor function: next(v) = v[0] ? ((v >> 1) ^ FEEDBACK_POLY) : (v >> 1), all NUM_BITS wide.
- States: HUNT, VERIFY, LOCKED. Internal run counter r__run (width ≥ clog2(max(LOCK_COUNT, UNLOCK_ERRORS))+1).
- Inputs with i__valid=0 have no effect anywhere (no state, counter or prediction change).
- HUNT, valid word w:
  - w == 0 (lockup value): ignore, stay HUNT.
  - else expected <= next(w), r__run <= 0, go VERIFY.
- VERIFY, valid word w:
  - w == expected: expected <= next(w); if r__run+1 == LOCK_COUNT go LOCKED, r__run <= 0; else r__run++.
  - w != expected, w != 0: reseed, expected <= next(w), r__run <= 0, stay VERIFY.
  - w == 0: go HUNT, r__run <= 0.
- LOCKED, valid word w (expected always advances from its own value, never from w):
  - match: expected <= next(expected), o__match_count++, r__run <= 0.
  - mismatch (incl. w == 0): expected <= next(expected), o__error pulse, o__error_count++, r__run++; if r__run+1 == UNLOCK_ERRORS go HUNT, r__run <= 0.
- Counters increment only in LOCKED; saturate at 32'hFFFF_FFFF.
- i__clear_counts: both counters to 0 next cycle; wins over a same-cycle increment. Does not affect state or lock.
- NUM_BITS outside 2..52 or FEEDBACK_POLY == 0: behaviour undefined; elaboration-time assertion fires.

## Timing
- Fully registered outputs; one word per cycle sustained, no back-pressure.
- Reset: state HUNT, r__run 0, o__locked 0, o__error 0, o__expected 0, both counters 0. Reset mid-stream discards lock and prediction; next valid nonzero word reseeds.
- o__error asserts in the cycle after the mismatching valid word, for exactly one cycle; back-to-back mismatches give back-to-back pulses.
- o__locked rises the cycle after the LOCK_COUNT-th consecutive match in VERIFY; falls the cycle after the UNLOCK_ERRORS-th consecutive locked mismatch (that word's o__error pulse is still emitted, same cycle as the fall).
- o__expected updates the cycle after each accepted valid word.
- Minimum lock latency: LOCK_COUNT+1 valid words (one seed + LOCK_COUNT matches).

## Test plan
All with NUM_BITS=16, FEEDBACK_POLY=16'hD008, LOCK_COUNT=4, UNLOCK_ERRORS=3.
- Clean lock: valid words 0001, D008, 6804, 3402, 1A01 on consecutive cycles -> o__locked=1 the cycle after 1A01, o__expected=DD08, counters 0, no o__error.
- Locked tracking with gaps: after lock, send DD08, idle 3 cycles, then next(DD08) -> o__match_count=2, o__error never asserts, o__locked stays 1.
- Single error flywheel: locked, send FFFF instead of DD08 then the correct successor of DD08 -> one o__error pulse, o__error_count=1, o__match_count=1, o__locked stays 1.
- Loss of lock: locked, three consecutive wrong words -> three o__error pulses, o__error_count=3, o__locked falls with the third pulse; state HUNT, next 5-word clean sequence relocks.
- Zero handling and reseed: in HUNT send 0000 x3 -> stays HUNT, o__expected=0; in VERIFY after seed 0001 send 1234 -> o__expected=next(1234)=091A, no error pulse, no lock.
- Clear vs. saturate and reset: force counts via clear+traffic, assert i__clear_counts same cycle as a match -> o__match_count=0; assert reset while locked -> all outputs 0 next cycle.
